csr_trap_seq: RTL and testbench
===============================

Name: csr_trap_seq

Overview:
- Writeback-stage sequencer that sits directly upstream of the CSR register file.
- Turns committed Zicsr instructions, mret and synchronous exceptions or interrupts into reads and writes on the CSR file's single read port and single write port.
- Sequences multi-register trap entry over several cycles, stalls commit while busy, and produces the PC redirect for traps and mret.

Parameters:
- XLEN, 64, data/PC width (word_t).
- VECTORED_EN, 1, when 1 honour mtvec.mode=1 (vectored) for interrupts; when 0 always direct.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- commit_valid  in  1  instruction offered at writeback
- commit_ready  out  1  =1 only in IDLE; transfer when valid&&ready
- commit_pc  in  XLEN  PC of offered instruction
- csr_op  in  2  0=none 1=RW 2=RS 3=RC
- csr_addr  in  12  CSR address of instruction
- csr_src  in  XLEN  rs1 value or zero-extended zimm
- is_mret  in  1  instruction is mret
- exc_valid  in  1  exception/interrupt to take
- exc_intr  in  1  1=interrupt, 0=exception
- exc_code  in  4  cause code
- exc_tval  in  XLEN  trap value
- csr_ra  out  12  CSR read address
- csr_rd  in  XLEN  CSR read data, combinational from csr_ra
- csr_wvalid  out  1  CSR write enable
- csr_wa  out  12  CSR write address
- csr_wd  out  XLEN  CSR write data
- csr_is_mret  out  1  one-cycle mret pulse to CSR file
- result_valid  out  1  old CSR value ready for rd writeback
- result  out  XLEN  old CSR value
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  XLEN  redirect target

Behaviour:
- FSM states: IDLE, CSR_WR, MRET, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP. The state is registered; all outputs decode combinationally from the state and latched fields.
- Reset (async): state=IDLE and all latches cleared. All outputs 0 except commit_ready=1 and csr_ra=csr_addr. Reset mid-sequence abandons the trap or write with no further CSR writes and no redirect.
- IDLE:
  - csr_ra=csr_addr.
  - On accept (cycle 0), priority is exc_valid > csr_op!=0 > is_mret > plain (no state change).
  - Exception: latch pc, intr, code, tval -> T_EPC.
  - CSR op: latch old=csr_rd, addr. Compute new: RW new=src; RS new=old|src; RC new=old&~src. Latch do_write=(op==RW)||(src!=0). -> CSR_WR.
  - mret: csr_ra=0x341, latch mepc=csr_rd -> MRET.
- CSR_WR (cycle 1): result_valid=1, result=old. csr_wvalid=do_write, wa=addr, wd=new. -> IDLE.
- MRET (cycle 1): csr_is_mret=1, csr_wvalid=0, redirect_valid=1, redirect_pc=latched mepc. -> IDLE.
- Trap sequence, one CSR write per cycle, cycles 1..4:
  - T_EPC: write 0x341 (mepc) = {pc[XLEN-1:2],2'b00}.
  - T_CAUSE: write 0x342 (mcause) = {intr, zeros, code}.
  - T_TVAL: write 0x343 (mtval) = tval. Same cycle csr_ra=0x305; latch mtvec=csr_rd.
  - T_STATUS: csr_ra=0x300. Write 0x300 = csr_rd with bit7(MPIE)=bit3(MIE), bit3=0, bits[12:11](MPP)=2'b11.
- T_JUMP (cycle 5):
  - redirect_valid=1. redirect_pc = {mtvec[XLEN-1:2],2'b00}, plus 4*code when VECTORED_EN && mtvec[1:0]==1 && intr.
  - -> IDLE; commit_ready=1 again in cycle 6.
- Latencies:
  - CSR instruction: result and write 1 cycle after accept.
  - mret: redirect 1 cycle after accept.
  - Trap: 4 writes in cycles 1..4, redirect in cycle 5.
- Outputs outside their active states:
  - csr_wvalid, result_valid, redirect_valid and csr_is_mret are never asserted outside their listed states.
  - redirect_pc, result, csr_wa and csr_wd hold 0 whenever the corresponding valid is 0.
- commit_valid while busy is ignored; the producer holds it.
- Widths: all arithmetic is XLEN bits; code is zero-extended; shift 4*code fits without overflow.

Test Plan:
- CSRRW: reset, mscratch(0x340) rd=0x5, accept op=RW src=0xA -> cycle1 result=0x5, wvalid=1 wa=0x340 wd=0xA, commit_ready back in cycle2.
- CSRRS/CSRRC: RS src=0 old=0xF0 -> result=0xF0, no write. RC src=0x30 old=0xF0 -> wd=0xC0.
- Exception: pc=0x80000104, code=2, tval=0xDEAD, mtvec=0x80001000, mstatus=0x8 -> writes mepc=0x80000104, mcause=0x2, mtval=0xDEAD, mstatus=0x1880 in cycles 1..4; cycle5 redirect 0x80001000; commit_ready=0 cycles 1-5.
- Vectored interrupt: mtvec=0x80001001, intr=1, code=7 -> mcause=0x8000_0000_0000_0007, redirect 0x8000101C. Same with intr=0 -> redirect 0x80001000.
- mret: mepc=0x80000200 -> cycle1 csr_is_mret=1, redirect 0x80000200, no write. exc_valid+is_mret+csr_op together -> trap path only.
- Async reset asserted during T_CAUSE -> outputs 0 immediately; after release no further writes or redirect; commit_ready=1.

Source files
------------

// File: rtl/csr_trap_seq.sv
// csr_trap_seq: writeback sequencer driving the CSR file for Zicsr ops, mret and trap entry.
module csr_trap_seq #(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_src,
  input  logic            is_mret,
  input  logic            exc_valid,
  input  logic            exc_intr,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_tval,
  output logic [11:0]     csr_ra,
  input  logic [XLEN-1:0] csr_rd,
  output logic            csr_wvalid,
  output logic [11:0]     csr_wa,
  output logic [XLEN-1:0] csr_wd,
  output logic            csr_is_mret,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CSR_WR   = 3'd1;
  localparam logic [2:0] MRET     = 3'd2;
  localparam logic [2:0] T_EPC    = 3'd3;
  localparam logic [2:0] T_CAUSE  = 3'd4;
  localparam logic [2:0] T_TVAL   = 3'd5;
  localparam logic [2:0] T_STATUS = 3'd6;
  localparam logic [2:0] T_JUMP   = 3'd7;
  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, tval_q, old_q, new_q, mtvec_q;
  logic [11:0]     addr_q;
  logic [3:0]      code_q;
  logic            intr_q, wr_q;
  logic            accept, take_exc, take_op, take_mret;
  logic [XLEN-1:0] new_val, status_wd, vec_off;
  assign accept    = commit_valid && state_q == IDLE;
  assign take_exc  = accept && exc_valid;
  assign take_op   = accept && !exc_valid && csr_op != 2'd0;
  assign take_mret = accept && !exc_valid && csr_op == 2'd0 && is_mret;
  assign new_val   = csr_op == 2'd1 ? csr_src : csr_op == 2'd2 ? (csr_rd | csr_src) : (csr_rd & ~csr_src);
  assign vec_off   = (VECTORED_EN && mtvec_q[1:0] == 2'b01 && intr_q) ? (XLEN'(code_q) << 2) : '0;
  // mstatus trap update: MPIE<=MIE, MIE<=0, MPP<=M
  always_comb begin
    status_wd        = csr_rd;
    status_wd[7]     = csr_rd[3];
    status_wd[3]     = 1'b0;
    status_wd[12:11] = 2'b11;
  end
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:     state_d = take_exc ? T_EPC : take_op ? CSR_WR : take_mret ? MRET : IDLE;
      T_EPC:    state_d = T_CAUSE;
      T_CAUSE:  state_d = T_TVAL;
      T_TVAL:   state_d = T_STATUS;
      T_STATUS: state_d = T_JUMP;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      tval_q  <= '0;
      old_q   <= '0;
      new_q   <= '0;
      mtvec_q <= '0;
      addr_q  <= '0;
      code_q  <= '0;
      intr_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_exc) begin
        pc_q   <= commit_pc;
        intr_q <= exc_intr;
        code_q <= exc_code;
        tval_q <= exc_tval;
      end
      if (take_op) begin
        old_q  <= csr_rd;
        new_q  <= new_val;
        addr_q <= csr_addr;
        wr_q   <= csr_op == 2'd1 || csr_src != '0;
      end
      if (take_mret) pc_q <= csr_rd;
      if (state_q == T_TVAL) mtvec_q <= csr_rd;
    end
  end
  always_comb begin
    commit_ready   = state_q == IDLE;
    csr_ra         = '0;
    csr_wvalid     = 1'b0;
    csr_wa         = '0;
    csr_wd         = '0;
    csr_is_mret    = 1'b0;
    result_valid   = 1'b0;
    result         = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE:   csr_ra = take_mret ? 12'h341 : csr_addr;
      CSR_WR: begin
        result_valid = 1'b1;
        result       = old_q;
        csr_wvalid   = wr_q;
        csr_wa       = wr_q ? addr_q : '0;
        csr_wd       = wr_q ? new_q : '0;
      end
      MRET: begin
        csr_is_mret    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = pc_q;
      end
      T_EPC: begin
        csr_wvalid = 1'b1;
        csr_wa     = 12'h341;
        csr_wd     = {pc_q[XLEN-1:2], 2'b00};
      end
      T_CAUSE: begin
        csr_wvalid = 1'b1;
        csr_wa     = 12'h342;
        csr_wd     = {intr_q, {(XLEN-5){1'b0}}, code_q};
      end
      T_TVAL: begin
        csr_ra     = 12'h305;
        csr_wvalid = 1'b1;
        csr_wa     = 12'h343;
        csr_wd     = tval_q;
      end
      T_STATUS: begin
        csr_ra     = 12'h300;
        csr_wvalid = 1'b1;
        csr_wa     = 12'h300;
        csr_wd     = status_wd;
      end
      T_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = {mtvec_q[XLEN-1:2], 2'b00} + vec_off;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_csr_trap_seq.sv
// tb_csr_trap_seq: directed and random transactions against a CSR-file model and per-cycle expectations.
module tb_csr_trap_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid, commit_ready, is_mret, exc_valid, exc_intr;
  logic [63:0] commit_pc, csr_src, exc_tval, csr_rd, csr_wd, result, redirect_pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr, csr_ra, csr_wa;
  logic [3:0]  exc_code;
  logic        csr_wvalid, csr_is_mret, result_valid, redirect_valid;
  logic [63:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;

  csr_trap_seq #(.XLEN(64), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .csr_op(csr_op), .csr_addr(csr_addr), .csr_src(csr_src),
    .is_mret(is_mret), .exc_valid(exc_valid), .exc_intr(exc_intr), .exc_code(exc_code),
    .exc_tval(exc_tval), .csr_ra(csr_ra), .csr_rd(csr_rd), .csr_wvalid(csr_wvalid),
    .csr_wa(csr_wa), .csr_wd(csr_wd), .csr_is_mret(csr_is_mret), .result_valid(result_valid),
    .result(result), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;
  assign csr_rd = mem[csr_ra];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check all outputs mid-cycle, then let the modelled CSR file absorb any write.
  task automatic cyc(input string tag, input logic rdy, input logic wv, input logic [11:0] wa,
                     input logic [63:0] wd, input logic rv, input logic [63:0] res,
                     input logic redv, input logic [63:0] rpc, input logic im);
    logic        w;
    logic [11:0] a;
    logic [63:0] d;
    @(negedge clk);
    chk({tag, ".ready"}, 64'(commit_ready), 64'(rdy));
    chk({tag, ".wvalid"}, 64'(csr_wvalid), 64'(wv));
    chk({tag, ".wa"}, 64'(csr_wa), 64'(wa));
    chk({tag, ".wd"}, csr_wd, wd);
    chk({tag, ".rvalid"}, 64'(result_valid), 64'(rv));
    chk({tag, ".result"}, result, res);
    chk({tag, ".redv"}, 64'(redirect_valid), 64'(redv));
    chk({tag, ".redpc"}, redirect_pc, rpc);
    chk({tag, ".mret"}, 64'(csr_is_mret), 64'(im));
    w = csr_wvalid; a = csr_wa; d = csr_wd;
    @(posedge clk); #1;
    if (w) mem[a] = d;
  endtask

  task automatic idle_inputs();
    commit_valid = 0; exc_valid = 0; is_mret = 0; csr_op = 0;
  endtask

  // Offer one instruction (called just after a rising edge) and check the whole response.
  task automatic txn(input string tag, input logic exc, input logic intr, input logic [3:0] code,
                     input logic [63:0] tval, input logic [63:0] pc, input logic [1:0] op,
                     input logic [11:0] addr, input logic [63:0] src, input logic mr);
    logic [63:0] old, nw, ms, mt, mepc, stat, tgt, cause;
    logic        dw;
    commit_valid = 1; commit_pc = pc; csr_op = op; csr_addr = addr; csr_src = src;
    is_mret = mr; exc_valid = exc; exc_intr = intr; exc_code = code; exc_tval = tval;
    @(negedge clk);
    chk({tag, ".ready0"}, 64'(commit_ready), 64'd1);
    chk({tag, ".ra0"}, 64'(csr_ra), (!exc && op == 0 && mr) ? 64'h341 : 64'(addr));
    old  = mem[addr];
    ms   = mem[12'h300];
    mt   = mem[12'h305];
    mepc = mem[12'h341];
    nw   = op == 1 ? src : op == 2 ? (old | src) : (old & ~src);
    dw   = op == 1 || src != 0;
    stat = (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
    tgt  = (mt & ~64'h3) + ((mt[1:0] == 2'b01 && intr) ? 64'(code) * 4 : 64'h0);
    cause = (intr ? 64'h8000_0000_0000_0000 : 64'h0) + 64'(code);
    @(posedge clk); #1;
    idle_inputs();
    if (exc) begin
      cyc({tag, ".epc"},    0, 1, 12'h341, pc & ~64'h3, 0, 0, 0, 0, 0);
      cyc({tag, ".cause"},  0, 1, 12'h342, cause,       0, 0, 0, 0, 0);
      cyc({tag, ".tval"},   0, 1, 12'h343, tval,        0, 0, 0, 0, 0);
      cyc({tag, ".status"}, 0, 1, 12'h300, stat,        0, 0, 0, 0, 0);
      cyc({tag, ".jump"},   0, 0, 0, 0, 0, 0, 1, tgt, 0);
    end else if (op != 0)
      cyc({tag, ".wr"}, 0, dw, dw ? addr : 12'h0, dw ? nw : 64'h0, 1, old, 0, 0, 0);
    else if (mr)
      cyc({tag, ".mret"}, 0, 0, 0, 0, 0, 0, 1, mepc, 1);
    cyc({tag, ".idle"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    idle_inputs();
    commit_pc = 0; csr_addr = 12'h123; csr_src = 0; exc_intr = 0; exc_code = 0; exc_tval = 0;
    reset = 1;
    #1;
    chk("rst.ready", 64'(commit_ready), 64'd1);
    chk("rst.ra", 64'(csr_ra), 64'h123);
    chk("rst.wvalid", 64'(csr_wvalid), 64'd0);
    chk("rst.redv", 64'(redirect_valid), 64'd0);
    chk("rst.rvalid", 64'(result_valid), 64'd0);
    @(posedge clk); #1;
    reset = 0;

    mem[12'h340] = 64'h5;
    txn("rw", 0, 0, 0, 0, 0, 2'd1, 12'h340, 64'hA, 0);
    chk("rw.mem", mem[12'h340], 64'hA);
    mem[12'h340] = 64'hF0;
    txn("rs0", 0, 0, 0, 0, 0, 2'd2, 12'h340, 64'h0, 0);
    txn("rc", 0, 0, 0, 0, 0, 2'd3, 12'h340, 64'h30, 0);
    chk("rc.mem", mem[12'h340], 64'hC0);
    txn("plain", 0, 0, 0, 0, 64'h40, 2'd0, 12'h340, 64'h0, 0);

    mem[12'h305] = 64'h8000_1000; mem[12'h300] = 64'h8;
    txn("exc", 1, 0, 4'd2, 64'hDEAD, 64'h8000_0104, 0, 0, 0, 0);
    chk("exc.mstatus", mem[12'h300], 64'h1880);
    mem[12'h305] = 64'h8000_1001;
    txn("vint", 1, 1, 4'd7, 64'h0, 64'h8000_0300, 0, 0, 0, 0);
    chk("vint.mcause", mem[12'h342], 64'h8000_0000_0000_0007);
    txn("vexc", 1, 0, 4'd7, 64'h0, 64'h8000_0302, 0, 0, 0, 0);

    mem[12'h341] = 64'h8000_0200;
    txn("mret", 0, 0, 0, 0, 0, 2'd0, 12'h0, 0, 1);
    txn("prio", 1, 0, 4'd3, 64'h77, 64'h8000_0400, 2'd1, 12'h340, 64'h99, 1);

    commit_valid = 1; exc_valid = 1; exc_intr = 0; exc_code = 4'd5; commit_pc = 64'h1000;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("rstmid.cause_wv", 64'(csr_wvalid), 64'd1);
    chk("rstmid.cause_wa", 64'(csr_wa), 64'h342);
    #2 reset = 1;
    #1;
    chk("rstmid.wvalid", 64'(csr_wvalid), 64'd0);
    chk("rstmid.wd", csr_wd, 64'd0);
    chk("rstmid.ready", 64'(commit_ready), 64'd1);
    chk("rstmid.ra", 64'(csr_ra), 64'(csr_addr));
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 6; i++) cyc("rstmid.after", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [63:0] r;
      kind = $urandom_range(0, 3);
      r = {$urandom, $urandom};
      mem[12'h305] = (r & ~64'h3) | 64'($urandom_range(0, 1));
      mem[12'h300] = {$urandom, $urandom};
      mem[12'h341] = {$urandom, $urandom};
      txn("rnd", kind == 0 || $urandom_range(0, 7) == 0, 1'($urandom), 4'($urandom),
          {$urandom, $urandom}, {$urandom, $urandom},
          kind == 1 ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 1) * $urandom_range(1, 3)),
          12'($urandom), $urandom_range(0, 3) == 0 ? 64'h0 : {$urandom, $urandom},
          kind == 2 || 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
